// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: single-port data-memory controller shared by the
// load/store unit and the stack unit. It arbitrates round-robin, owns the
// stack pointer, issues one memory command per grant and returns read data.
// Optional overflow/underflow guard: define DMEM_STACK_GUARD_EN.
module dmem_access_arbiter #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned STACK_TOP   = 255,
  parameter int unsigned STACK_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  input  logic        stk_req,
  input  logic        stk_pop,
  input  logic [31:0] stk_wdata,
  output logic        stk_gnt,
  output logic        stk_rvalid,
  output logic [31:0] stk_rdata,
  output logic        stk_err,
  output logic [7:0]  sp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

`ifdef DMEM_STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [7:0]  SP_TOP   = 8'(STACK_TOP);
  localparam logic [7:0]  SP_DEPTH = 8'(STACK_DEPTH);
  localparam logic [29:0] WMASK    = 30'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_e;

  state_e      state_q;
  logic        ls_gnt_q, stk_gnt_q, ls_rvalid_q, stk_rvalid_q, stk_err_q;
  logic        mem_read_q, mem_write_q;
  logic [31:0] mem_addr_q, mem_wdata_q, ls_rdata_q, stk_rdata_q;
  logic [7:0]  sp_q;
  logic        last_stk_q, win_stk_q, rd_q, err_q;

  logic        pick_stk_d, rd_d, err_d;
  logic [31:0] addr_d, wdata_d;
  logic [7:0]  depth;
  logic        stk_full, stk_empty;

  // Winner selection and the command it would issue, evaluated from IDLE
  always_comb begin
    pick_stk_d = stk_req;
    if (ls_req && stk_req) pick_stk_d = ~last_stk_q;
    depth     = SP_TOP - sp_q;
    stk_full  = (depth == SP_DEPTH);
    stk_empty = (sp_q == SP_TOP);
    rd_d      = ~ls_we;
    err_d     = 1'b0;
    addr_d    = ls_addr & {WMASK, 2'b00};
    wdata_d   = ls_wdata;
    if (pick_stk_d) begin
      rd_d    = stk_pop;
      err_d   = GUARD_EN & (stk_pop ? stk_empty : stk_full);
      addr_d  = {22'd0, (stk_pop ? 8'(sp_q + 8'd1) : sp_q), 2'b00};
      wdata_d = stk_wdata;
    end
  end

  // Access sequencer: arbitration, command issue, response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ls_gnt_q     <= 1'b0;
      stk_gnt_q    <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      stk_rvalid_q <= 1'b0;
      stk_err_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ls_rdata_q   <= '0;
      stk_rdata_q  <= '0;
      sp_q         <= SP_TOP;
      last_stk_q   <= 1'b1;
      win_stk_q    <= 1'b0;
      rd_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ls_gnt_q     <= 1'b0;
      stk_gnt_q    <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      stk_rvalid_q <= 1'b0;
      stk_err_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ls_req || stk_req) begin
            // Grant is presented in ISSUE; last-winner moves with it
            state_q     <= ISSUE;
            win_stk_q   <= pick_stk_d;
            last_stk_q  <= pick_stk_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            ls_gnt_q    <= ~pick_stk_d;
            stk_gnt_q   <= pick_stk_d;
            stk_err_q   <= err_d;
            mem_read_q  <= rd_d & ~err_d;
            mem_write_q <= ~rd_d & ~err_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
          end
        end
        ISSUE: begin
          if (win_stk_q && !err_q) sp_q <= rd_q ? 8'(sp_q + 8'd1) : 8'(sp_q - 8'd1);
          state_q <= (rd_q && !err_q) ? RD_WAIT : IDLE;
        end
        RD_WAIT: begin
          if (win_stk_q) begin
            stk_rdata_q  <= mem_rdata;
            stk_rvalid_q <= 1'b1;
          end else begin
            ls_rdata_q  <= mem_rdata;
            ls_rvalid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ls_gnt     = ls_gnt_q;
  assign stk_gnt    = stk_gnt_q;
  assign ls_rvalid  = ls_rvalid_q;
  assign stk_rvalid = stk_rvalid_q;
  assign ls_rdata   = ls_rdata_q;
  assign stk_rdata  = stk_rdata_q;
  assign stk_err    = stk_err_q;
  assign sp         = sp_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Testbench for dmem_access_arbiter: directed steps, memory model,
// scoreboard of expected memory commands and read responses.
module tb_dmem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        stk_req = 1'b0, stk_pop = 1'b0;
  logic [31:0] stk_wdata = '0;
  logic        stk_gnt, stk_rvalid, stk_err;
  logic [31:0] stk_rdata;
  logic [7:0]  sp;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        stk;
    logic        rd;
    logic        wr;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ls_rq[$];
  logic [31:0] stk_rq[$];
  exp_t        me;

  dmem_access_arbiter #(.MEM_WORDS(256), .STACK_TOP(255), .STACK_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .stk_req(stk_req), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_gnt(stk_gnt), .stk_rvalid(stk_rvalid), .stk_rdata(stk_rdata),
    .stk_err(stk_err), .sp(sp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read
  logic [31:0] mem_m [256];
  always @(posedge clk) begin
    if (mem_write) mem_m[mem_addr[9:2]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_m[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every grant against the expected command, every response against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (ls_gnt || stk_gnt) begin
        chk("single_gnt", 32'(ls_gnt & stk_gnt), 32'd0);
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'(ls_gnt | stk_gnt), 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("gnt_owner", 32'(stk_gnt), 32'(me.stk));
          chk("mem_read", 32'(mem_read), 32'(me.rd));
          chk("mem_write", 32'(mem_write), 32'(me.wr));
          chk("stk_err", 32'(stk_err), 32'(me.err));
          if (me.rd || me.wr) chk("mem_addr", mem_addr, me.addr);
          if (me.wr) chk("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (ls_rvalid) begin
        if (ls_rq.size() == 0) chk("ls_rvalid_unexpected", 32'(ls_rvalid), 32'd0);
        else chk("ls_rdata", ls_rdata, ls_rq.pop_front());
      end
      if (stk_rvalid) begin
        if (stk_rq.size() == 0) chk("stk_rvalid_unexpected", 32'(stk_rvalid), 32'd0);
        else chk("stk_rdata", stk_rdata, stk_rq.pop_front());
      end
    end
  end

  // Drive one request, queue its expectations, wait for the grant, return one cycle after it
  task automatic do_op(input bit is_stk, input bit rd, input bit err, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rexp, output int lat);
    exp_t e;
    bit   got;
    e.stk = is_stk; e.rd = rd & ~err; e.wr = ~rd & ~err; e.err = err;
    e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
    if (rd && !err) begin
      if (is_stk) stk_rq.push_back(rexp);
      else        ls_rq.push_back(rexp);
    end
    if (is_stk) begin
      stk_req = 1'b1; stk_pop = rd; stk_wdata = wdata;
    end else begin
      ls_req = 1'b1; ls_we = ~rd; ls_addr = addr; ls_wdata = wdata;
    end
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (is_stk ? stk_gnt : ls_gnt) got = 1'b1;
    end
    if (is_stk) begin
      chk("stk_gnt_seen", 32'(got), 32'd1);
      stk_req = 1'b0;
    end else begin
      chk("ls_gnt_seen", 32'(got), 32'd1);
      ls_req = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int cyc;
    int last_g;
    int cnt;
    logic [3:0] order;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_stk_gnt", 32'(stk_gnt), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_stk_rdata", stk_rdata, 32'd0);
    chk("rst_rvalid", 32'({ls_rvalid, stk_rvalid, stk_err}), 32'd0);
    chk("rst_sp", 32'(sp), 32'd255);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load through the LS port
    do_op(1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, lat);
    chk("store_gnt_latency", 32'(lat), 32'd1);
    do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);
    @(negedge clk);
    chk("load_rvalid_at_T2", 32'(ls_rvalid), 32'd1);
    chk("load_rdata", ls_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("load_rvalid_one_cycle", 32'(ls_rvalid), 32'd0);
    chk("load_rdata_held", ls_rdata, 32'hDEADBEEF);

    // Push, push, pop, pop
    do_op(1'b1, 1'b0, 1'b0, 32'h3FC, 32'h11, 32'h0, lat);
    chk("sp_push1", 32'(sp), 32'd254);
    do_op(1'b1, 1'b0, 1'b0, 32'h3F8, 32'h22, 32'h0, lat);
    chk("sp_push2", 32'(sp), 32'd253);
    do_op(1'b1, 1'b1, 1'b0, 32'h3F8, 32'h0, 32'h22, lat);
    chk("sp_pop1", 32'(sp), 32'd254);
    do_op(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 32'h11, lat);
    chk("sp_pop2", 32'(sp), 32'd255);
    repeat (3) @(negedge clk);
    chk("pop_rdata_held", stk_rdata, 32'h11);

    // Both requesters held continuously: grants alternate, LS first (STK won last)
    exp_q.push_back('{stk: 1'b0, rd: 1'b0, wr: 1'b1, err: 1'b0, addr: 32'h40, wdata: 32'hCAFE0001});
    exp_q.push_back('{stk: 1'b1, rd: 1'b0, wr: 1'b1, err: 1'b0, addr: 32'h3FC, wdata: 32'h33});
    exp_q.push_back('{stk: 1'b0, rd: 1'b0, wr: 1'b1, err: 1'b0, addr: 32'h40, wdata: 32'hCAFE0001});
    exp_q.push_back('{stk: 1'b1, rd: 1'b0, wr: 1'b1, err: 1'b0, addr: 32'h3F8, wdata: 32'h33});
    ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hCAFE0001;
    stk_pop = 1'b0; stk_wdata = 32'h33;
    ls_req = 1'b1; stk_req = 1'b1;
    k = 0; order = '0; last_g = 0;
    for (cyc = 1; cyc <= 30 && k < 4; cyc++) begin
      @(negedge clk);
      if (ls_gnt || stk_gnt) begin
        order[k] = stk_gnt;
        if (k > 0) chk("rr_write_spacing", 32'(cyc - last_g), 32'd2);
        last_g = cyc;
        k++;
      end
    end
    ls_req = 1'b0; stk_req = 1'b0;
    chk("rr_grant_count", 32'(k), 32'd4);
    chk("rr_order", 32'(order), 32'b1010);
    @(negedge clk);
    chk("rr_sp", 32'(sp), 32'd253);
    do_op(1'b1, 1'b1, 1'b0, 32'h3F8, 32'h0, 32'h33, lat);
    do_op(1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 32'h33, lat);
    chk("rr_sp_restored", 32'(sp), 32'd255);
    repeat (3) @(negedge clk);

    // Reset during RD_WAIT of a load aborts it
    do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);
    rst_n = 1'b0;
    ls_rq.delete();
    #1;
    chk("arst_mem_read", 32'(mem_read), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_ls_rdata", ls_rdata, 32'd0);
    chk("arst_stk_rdata", stk_rdata, 32'd0);
    chk("arst_sp", 32'(sp), 32'd255);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ls_rvalid) cnt++;
    end
    chk("arst_no_rvalid", 32'(cnt), 32'd0);
    chk("arst_rdata_still0", ls_rdata, 32'd0);

`ifdef DMEM_STACK_GUARD_EN
    // POP on empty: error pulse, no access, no response
    do_op(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, lat);
    chk("guard_pop_sp", 32'(sp), 32'd255);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stk_rvalid) cnt++;
    end
    chk("guard_pop_no_rvalid", 32'(cnt), 32'd0);
    // Fill to STACK_DEPTH, then one push too many
    for (int i = 0; i < 64; i++) begin
      do_op(1'b1, 1'b0, 1'b0, {22'd0, 8'(255 - i), 2'b00}, 32'(i) + 32'h100, 32'h0, lat);
    end
    chk("guard_full_sp", 32'(sp), 32'd191);
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'hBAD, 32'h0, lat);
    chk("guard_overflow_sp", 32'(sp), 32'd191);
`else
    // Unchecked build: POP on empty wraps sp to 0, PUSH wraps it back
    do_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0BADF00D, 32'h0, lat);
    do_op(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, lat);
    chk("wrap_pop_sp", 32'(sp), 32'd0);
    do_op(1'b1, 1'b0, 1'b0, 32'h0, 32'h77, 32'h0, lat);
    chk("wrap_push_sp", 32'(sp), 32'd255);
`endif

    repeat (6) @(negedge clk);
    chk("cmd_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("ls_resp_drained", 32'(ls_rq.size()), 32'd0);
    chk("stk_resp_drained", 32'(stk_rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Single-port controller in front of the 256-word data memory.
- Shares the memory between two requesters:
  - the load/store (LS) unit;
  - the stack unit (PUSH/POP).
- Owns the stack pointer and sequences every access: arbitration, command issue, read-response capture.
- It is the only block that drives the memory's memRead, memWrite, address and Data_in.

Parameters:
- MEM_WORDS, 256, memory depth in 32-bit words.
- STACK_TOP, 255, word index of the first push slot (stack grows down).
- STACK_DEPTH, 64, maximum number of stacked words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ls_req  in  1  LS request; held high with payload until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  LS byte address; word-aligned, bits [1:0] ignored.
- ls_wdata  in  32  store data.
- ls_gnt  out  1  one-cycle grant pulse.
- ls_rvalid  out  1  one-cycle load-data-valid pulse.
- ls_rdata  out  32  load data, held until next load response.
- stk_req  in  1  stack request; held until stk_gnt.
- stk_pop  in  1  1 = POP, 0 = PUSH.
- stk_wdata  in  32  push data.
- stk_gnt  out  1  one-cycle grant pulse.
- stk_rvalid  out  1  one-cycle pop-data-valid pulse.
- stk_rdata  out  32  pop data, held until next pop response.
- stk_err  out  1  one-cycle overflow/underflow pulse; guard builds only, else tied 0.
- sp  out  8  current stack pointer, word index.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  memory byte address (word index << 2).
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; registered by memory, valid the cycle after mem_read.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE;
  - all strobes, gnt, rvalid, err = 0;
  - rdata, mem_addr, mem_wdata = 0;
  - sp = STACK_TOP; last-winner = STK;
  - memory contents untouched.
  - Reset mid-access aborts the access; no response is produced after release.
- FSM states IDLE, ISSUE, RD_WAIT, RESP; all outputs registered.
- IDLE:
  - Sample requests and pick a winner.
  - Latch its command: op, word address, data.
  - Go to ISSUE next cycle. No request: stay.
- Arbitration (round-robin):
  - Both requesting: the requester that did not win last is chosen.
  - Single requester always wins.
  - last-winner is updated on every grant.
- ISSUE (exactly one cycle):
  - Winner's gnt=1.
  - mem_read or mem_write=1 with mem_addr/mem_wdata valid.
  - Write, or any errored stack op: go to IDLE.
  - Read (load or POP): go to RD_WAIT.
  - Requests seen during ISSUE are ignored. A requester still holding req after its gnt cycle is treated as a new request.
- RD_WAIT: strobes 0; capture mem_rdata into the winner's rdata register at the end of the cycle.
- RESP: winner's rvalid=1 for one cycle; go to IDLE.
- Latency:
  - Load/POP: gnt in cycle T, rvalid in T+2.
  - Store/PUSH: gnt in cycle T, memory written at end of T.
- Throughput: write every 2 cycles; read every 4 cycles.
- Stack addressing:
  - PUSH: word address = sp; sp <= sp-1 at end of ISSUE.
  - POP: word address = sp+1; sp <= sp+1 at end of ISSUE.
  - depth = STACK_TOP - sp.
  - Empty when sp == STACK_TOP; full when depth == STACK_DEPTH.
- sp arithmetic is 8-bit modulo.
- LS addresses are not checked against the stack region.

Optional Feature:
- Macro: DMEM_STACK_GUARD_EN.
- Defined:
  - PUSH when full or POP when empty performs no memory access (strobes 0 in ISSUE).
  - sp is unchanged.
  - stk_gnt and stk_err pulse together in ISSUE.
  - No stk_rvalid follows.
- Undefined:
  - No checks; sp wraps modulo 256.
  - stk_err is constant 0.

Test Plan:
- Reset, then ls_req store addr 0x10, data 0xDEADBEEF:
  - ls_gnt one cycle later;
  - mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF in the gnt cycle.
  - Then load 0x10 → ls_rvalid 2 cycles after ls_gnt, ls_rdata=0xDEADBEEF.
- PUSH 0x11, then PUSH 0x22, then POP twice:
  - mem_addr sequence 0x3FC, 0x3F8, 0x3F8, 0x3FC;
  - stk_rdata 0x22 then 0x11;
  - sp 255→254→253→254→255.
- ls_req and stk_req asserted together and held continuously:
  - grants alternate LS, STK, LS, STK;
  - never two gnts in the same cycle.
- rst_n pulsed low during RD_WAIT of a load:
  - outputs 0 immediately, sp=255;
  - no ls_rvalid after release.
- Guard build: POP on empty stack → stk_gnt=stk_err=1, mem_read=0, sp stays 255, no stk_rvalid.
- Guard build: 64 PUSHes, then a 65th PUSH → stk_err=1, no write, sp stays 191.
